// File: rtl/dispatch_2_avlstrm_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | dispatch_2_avlstrm_pkg : routing-mode constants and lane type shared by   |
// |                          the 1-to-2 stream dispatcher                     |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
package dispatch_2_avlstrm_pkg;

  localparam int ROUTE_RR  = 0;
  localparam int ROUTE_SEL = 1;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

endpackage
`default_nettype wire

// File: rtl/dispatch_2_avlstrm_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | avl_stream_if : valid/ready beat stream with producer and consumer views  |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
interface avl_stream_if #(
  parameter int DWIDTH = 8
);
  logic [DWIDTH-1:0] data;
  logic              valid;
  logic              ready;

  modport tx     (output data, output valid, input  ready);
  modport rx     (input  data, input  valid, output ready);
  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);
endinterface
`default_nettype wire

// File: rtl/dispatch_2_avlstrm_fifo2_reg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fifo2_reg : 2-entry register FIFO, simultaneous read/write allowed        |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module fifo2_reg #(
  parameter int DWIDTH = 8
) (
  input  wire logic              Clk,
  input  wire logic              Rst,
  input  wire logic              i_wr_en,
  input  wire logic [DWIDTH-1:0] i_wr_data,
  output logic                   o_full,
  input  wire logic              i_rd_en,
  output logic [DWIDTH-1:0]      o_rd_data,
  output logic                   o_empty
);

  logic [DWIDTH-1:0] r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_cnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_wr_en) begin
        r_mem[r_wptr] <= i_wr_data;
        r_wptr        <= ~r_wptr;
      end
      if (i_rd_en) begin
        r_rptr <= ~r_rptr;
      end
      case ({i_wr_en, i_rd_en})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_full    = (r_cnt == 2'd2);
  assign o_empty   = (r_cnt == 2'd0);
  assign o_rd_data = r_mem[r_rptr];

endmodule
`default_nettype wire

// File: rtl/dispatch_2_avlstrm.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | dispatch_2_avlstrm : 1-to-2 stream dispatcher, round-robin or data-bit    |
// |                      steering, order preserved, head-of-line blocking     |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module dispatch_2_avlstrm
  import dispatch_2_avlstrm_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int ROUTE_MODE = ROUTE_RR,
  parameter int SEL_BIT    = 0,
  parameter int CNT_WIDTH  = 32
) (
  input  wire logic        Clk,
  input  wire logic        Rst,
  avl_stream_if.rx         in,
  avl_stream_if.tx         out0,
  avl_stream_if.tx         out1,
  output logic [CNT_WIDTH-1:0] cnt_out0,
  output logic [CNT_WIDTH-1:0] cnt_out1
);

  generate
    if (SEL_BIT < 0 || SEL_BIT >= DWIDTH) begin : g_bad_sel_bit
      $error("dispatch_2_avlstrm: SEL_BIT (%0d) must be below DWIDTH (%0d)", SEL_BIT, DWIDTH);
    end
  endgenerate

  logic                 r_in_ready;
  lane_e                r_rr;
  logic [CNT_WIDTH-1:0] r_cnt0;
  logic [CNT_WIDTH-1:0] r_cnt1;

  logic              w_acc;
  logic              w_disp;
  logic              w_full;
  logic              w_empty;
  logic              w_full_nxt;
  logic              w_free0;
  logic              w_free1;
  logic [DWIDTH-1:0] w_head;
  lane_e             w_target;

  fifo2_reg #(
    .DWIDTH (DWIDTH)
  ) u_fifo (
    .Clk       (Clk),
    .Rst       (Rst),
    .i_wr_en   (w_acc),
    .i_wr_data (in.data),
    .o_full    (w_full),
    .i_rd_en   (w_disp),
    .o_rd_data (w_head),
    .o_empty   (w_empty)
  );

  generate
    if (ROUTE_MODE == ROUTE_SEL && SEL_BIT >= 0 && SEL_BIT < DWIDTH) begin : g_route_sel
      assign w_target = lane_e'(w_head[SEL_BIT]);
    end else begin : g_route_rr
      assign w_target = r_rr;
    end
  endgenerate

  assign w_acc   = in.valid & r_in_ready;
  assign w_free0 = ~out0.valid | out0.ready;
  assign w_free1 = ~out1.valid | out1.ready;
  assign w_disp  = ~w_empty & ((w_target == LANE0) ? w_free0 : w_free1);

  // Occupancy after this edge reaches 2 only if it is already 2 with no read,
  // or it is 1 and a write lands without a read.
  assign w_full_nxt = (w_full & ~w_disp) | (~w_full & ~w_empty & w_acc & ~w_disp);

  assign in.ready = r_in_ready;
  assign cnt_out0 = r_cnt0;
  assign cnt_out1 = r_cnt1;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_in_ready <= 1'b0;
      r_rr       <= LANE0;
    end else begin
      r_in_ready <= ~w_full_nxt;
      if (w_disp) begin
        r_rr <= lane_e'(~r_rr);
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out0.valid <= 1'b0;
      out0.data  <= '0;
      r_cnt0     <= '0;
    end else begin
      if (w_disp && w_target == LANE0) begin
        out0.valid <= 1'b1;
        out0.data  <= w_head;
      end else if (out0.ready) begin
        out0.valid <= 1'b0;
      end
      if (out0.valid && out0.ready) begin
        r_cnt0 <= r_cnt0 + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out1.valid <= 1'b0;
      out1.data  <= '0;
      r_cnt1     <= '0;
    end else begin
      if (w_disp && w_target == LANE1) begin
        out1.valid <= 1'b1;
        out1.data  <= w_head;
      end else if (out1.ready) begin
        out1.valid <= 1'b0;
      end
      if (out1.valid && out1.ready) begin
        r_cnt1 <= r_cnt1 + CNT_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dispatch_2_avlstrm.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_dispatch_2_avlstrm : scoreboard bench for a round-robin dispatcher     |
// |                         (4-bit counters) and a data-bit-select one        |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module tb_dispatch_2_avlstrm;
  import dispatch_2_avlstrm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  avl_stream_if #(.DWIDTH(8)) rr_in(), rr_o0(), rr_o1(), sl_in(), sl_o0(), sl_o1();
  logic [3:0]  rr_c0, rr_c1;
  logic [31:0] sl_c0, sl_c1;

  dispatch_2_avlstrm #(.DWIDTH(8), .ROUTE_MODE(ROUTE_RR), .SEL_BIT(0), .CNT_WIDTH(4)) dut_rr (
    .Clk(clk), .Rst(rst), .in(rr_in), .out0(rr_o0), .out1(rr_o1),
    .cnt_out0(rr_c0), .cnt_out1(rr_c1));

  dispatch_2_avlstrm #(.DWIDTH(8), .ROUTE_MODE(ROUTE_SEL), .SEL_BIT(0), .CNT_WIDTH(32)) dut_sel (
    .Clk(clk), .Rst(rst), .in(sl_in), .out0(sl_o0), .out1(sl_o1),
    .cnt_out0(sl_c0), .cnt_out1(sl_c1));

  int checks = 0;
  int errors = 0;

  // Expected beats per lane: index 0/1 = rr dut lanes, 2/3 = sel dut lanes.
  logic [7:0]  q0[$], q1[$], q2[$], q3[$];
  logic [31:0] mcnt [4];
  bit          hv   [4];
  logic [7:0]  hd   [4];
  int          acc  [2];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void qpush(int idx, logic [7:0] x);
    case (idx)
      0: q0.push_back(x);
      1: q1.push_back(x);
      2: q2.push_back(x);
      default: q3.push_back(x);
    endcase
  endfunction

  function automatic int qsize(int idx);
    case (idx)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [7:0] qpop(int idx);
    case (idx)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  function automatic void flush();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    for (int i = 0; i < 4; i++) begin
      mcnt[i] = 0;
      hv[i]   = 1'b0;
      hd[i]   = 8'h00;
    end
    acc[0] = 0;
    acc[1] = 0;
  endfunction

  // Reference routing: rr sends the k-th accepted beat since reset to lane k mod 2,
  // sel sends a beat to the lane named by its bit 0.
  function automatic void in_mon(int d, bit hs, logic [7:0] x);
    int lane;
    if (!hs) return;
    lane = (d == 0) ? (acc[0] % 2) : int'(x[0]);
    acc[d]++;
    qpush(d * 2 + lane, x);
  endfunction

  function automatic void out_mon(int idx, bit v, bit r, logic [7:0] x,
                                  logic [31:0] c, logic [31:0] mask);
    if (hv[idx]) begin
      chk($sformatf("lane%0d_hold_valid", idx), {31'd0, v}, 32'd1);
      chk($sformatf("lane%0d_hold_data", idx), {24'd0, x}, {24'd0, hd[idx]});
    end
    chk($sformatf("lane%0d_counter", idx), c, mcnt[idx] & mask);
    if (v && r) begin
      if (qsize(idx) == 0) begin
        checks++;
        errors++;
        $display("FAIL lane%0d_unexpected_beat: got %0h expected none at %0t", idx, x, $time);
      end else begin
        chk($sformatf("lane%0d_beat", idx), {24'd0, x}, {24'd0, qpop(idx)});
      end
      mcnt[idx]++;
    end
    hv[idx] = v & ~r;
    hd[idx] = x;
  endfunction

  // Scoreboard monitor: evaluates the handshakes that the next rising edge will commit.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      flush();
    end else begin
      in_mon(0, rr_in.valid & rr_in.ready, rr_in.data);
      in_mon(1, sl_in.valid & sl_in.ready, sl_in.data);
      out_mon(0, rr_o0.valid, rr_o0.ready, rr_o0.data, {28'd0, rr_c0}, 32'h0000_000F);
      out_mon(1, rr_o1.valid, rr_o1.ready, rr_o1.data, {28'd0, rr_c1}, 32'h0000_000F);
      out_mon(2, sl_o0.valid, sl_o0.ready, sl_o0.data, sl_c0, 32'hFFFF_FFFF);
      out_mon(3, sl_o1.valid, sl_o1.ready, sl_o1.data, sl_c1, 32'hFFFF_FFFF);
    end
  end

  task automatic drv_in(int d, bit v, logic [7:0] x);
    if (d == 0) begin
      rr_in.valid = v;
      rr_in.data  = x;
    end else begin
      sl_in.valid = v;
      sl_in.data  = x;
    end
  endtask

  task automatic drv_rdy(int d, bit r0, bit r1);
    if (d == 0) begin
      rr_o0.ready = r0;
      rr_o1.ready = r1;
    end else begin
      sl_o0.ready = r0;
      sl_o1.ready = r1;
    end
  endtask

  function automatic bit rdy(int d);
    return (d == 0) ? rr_in.ready : sl_in.ready;
  endfunction

  task automatic send(int d, logic [7:0] x, output int waits);
    drv_in(d, 1'b1, x);
    waits = 0;
    #1;
    while (!rdy(d) && waits < 200) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!rdy(d)) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: dut %0d beat %0h never accepted", d, x);
    end
    @(negedge clk);
  endtask

  task automatic idle(int d, int n);
    drv_in(d, 1'b0, 8'h00);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int w;
    drv_in(0, 1'b0, 8'h00);
    drv_in(1, 1'b0, 8'h00);
    drv_rdy(0, 1'b0, 1'b0);
    drv_rdy(1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    chk("reset_in_ready_rr", {31'd0, rr_in.ready}, 32'd0);
    chk("reset_in_ready_sel", {31'd0, sl_in.ready}, 32'd0);
    chk("reset_out_valid_rr", {30'd0, rr_o1.valid, rr_o0.valid}, 32'd0);
    chk("reset_out_valid_sel", {30'd0, sl_o1.valid, sl_o0.valid}, 32'd0);
    chk("reset_out_data_rr", {16'd0, rr_o1.data, rr_o0.data}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready_rr", {31'd0, rr_in.ready}, 32'd1);
    chk("post_reset_ready_sel", {31'd0, sl_in.ready}, 32'd1);

    // Round-robin streaming at full rate.
    drv_rdy(0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(0, 8'h10 + 8'(i), w);
      chk("rr_stream_no_stall", w, 0);
    end
    idle(0, 4);
    chk("rr_stream_cnt0", {28'd0, rr_c0}, 32'd4);
    chk("rr_stream_cnt1", {28'd0, rr_c1}, 32'd4);

    // Data-bit select with 1-cycle latency.
    drv_rdy(1, 1'b1, 1'b1);
    send(1, 8'h21, w);
    chk("sel_not_yet_visible", {31'd0, sl_o1.valid}, 32'd0);
    send(1, 8'h22, w);
    chk("sel_latency_valid", {31'd0, sl_o1.valid}, 32'd1);
    chk("sel_latency_data", {24'd0, sl_o1.data}, 32'h21);
    send(1, 8'h23, w);
    idle(1, 4);
    chk("sel_cnt0", sl_c0, 32'd1);
    chk("sel_cnt1", sl_c1, 32'd2);

    // Head-of-line stall: lane 1 blocked, odd beats pile up, even beat must wait.
    drv_rdy(1, 1'b1, 1'b0);
    send(1, 8'h01, w);
    send(1, 8'h03, w);
    send(1, 8'h05, w);
    drv_in(1, 1'b1, 8'h02);
    repeat (3) @(negedge clk);
    chk("hol_in_ready", {31'd0, sl_in.ready}, 32'd0);
    chk("hol_out1_valid", {31'd0, sl_o1.valid}, 32'd1);
    chk("hol_out1_data", {24'd0, sl_o1.data}, 32'h01);
    chk("hol_out0_idle", {31'd0, sl_o0.valid}, 32'd0);
    drv_rdy(1, 1'b1, 1'b1);
    send(1, 8'h02, w);
    idle(1, 6);
    chk("hol_cnt0", sl_c0, 32'd2);
    chk("hol_cnt1", sl_c1, 32'd5);

    // Reset with both output registers loaded and two beats buffered.
    drv_rdy(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send(0, 8'hA0 + 8'(i), w);
    idle(0, 2);
    chk("pre_reset_full", {31'd0, rr_in.ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("async_reset_valid", {30'd0, rr_o1.valid, rr_o0.valid}, 32'd0);
    chk("async_reset_ready", {31'd0, rr_in.ready}, 32'd0);
    chk("async_reset_cnt", {24'd0, rr_c1, rr_c0}, 32'd0);
    chk("async_reset_cnt_sel", sl_c0 | sl_c1, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("release_ready", {31'd0, rr_in.ready}, 32'd1);
    drv_rdy(0, 1'b1, 1'b1);
    idle(0, 5);
    chk("no_stale_beat", {30'd0, rr_o1.valid, rr_o0.valid}, 32'd0);

    // 4-bit counter wrap: 17 beats land on lane 0.
    for (int i = 0; i < 34; i++) send(0, 8'(i), w);
    idle(0, 5);
    chk("wrap_cnt0", {28'd0, rr_c0}, 32'd1);
    chk("wrap_cnt1", {28'd0, rr_c1}, 32'd1);

    // Randomised traffic with lane-0 ready toggling every cycle.
    for (int c = 0; c < 8000; c++) begin
      drv_in(0, $urandom_range(0, 3) != 0, 8'($urandom));
      drv_in(1, $urandom_range(0, 3) != 0, 8'($urandom));
      drv_rdy(0, ~rr_o0.ready, 1'($urandom));
      drv_rdy(1, ~sl_o0.ready, 1'($urandom));
      @(negedge clk);
    end

    drv_in(0, 1'b0, 8'h00);
    drv_in(1, 1'b0, 8'h00);
    drv_rdy(0, 1'b1, 1'b1);
    drv_rdy(1, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("drain_lane%0d", i), qsize(i), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
